// File: rtl/bat_input_sched_pkg.sv
// Shared definitions for the bat input scheduler: default widths/timings, side-state
// encoding and the keyboard direction decode.
package bat_input_sched_pkg;

  localparam int MOVE_W_DEF        = 9;
  localparam int KEY_STEP_DEF      = 4;
  localparam int WARMUP_FRAMES_DEF = 7;
  localparam int IDLE_FRAMES_DEF   = 1500;

  typedef enum logic {
    ST_AI    = 1'b0,
    ST_HUMAN = 1'b1
  } side_st_t;

  typedef enum logic [1:0] {
    KD_NONE = 2'b00,
    KD_UP   = 2'b01,
    KD_DOWN = 2'b10
  } key_dir_t;

  // key[1]=Q (up), key[0]=A (down); both or neither pressed means no move
  function automatic key_dir_t key_dir(input logic [1:0] key);
    key_dir_t d;
    d = KD_NONE;
    case (key)
      2'b10:   d = KD_UP;
      2'b01:   d = KD_DOWN;
      default: d = KD_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bat_input_sched_src_fsm.sv
// AI/HUMAN ownership FSM for one bat with its idle-frame counter.
// human_o is registered; expire_o is a same-cycle flag so the top can force that frame's move to 0.
module bat_input_sched_src_fsm
  import bat_input_sched_pkg::*;
#(
  parameter int IDLE_FRAMES = IDLE_FRAMES_DEF
) (
  input  logic fclk,
  input  logic game_reset,
  input  logic fe_i,
  input  logic act_i,
  output logic human_o,
  output logic expire_o
);

  localparam int IW = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FRAMES - 1);

  side_st_t      st_q;
  logic [IW-1:0] idle_q;
  logic          at_max;

  assign at_max   = (idle_q == IDLE_MAX);
  // activity in the same cycle as the timeout edge keeps the side human
  assign expire_o = fe_i & (st_q == ST_HUMAN) & at_max & ~act_i;
  assign human_o  = (st_q == ST_HUMAN);

  always_ff @(posedge fclk or posedge game_reset) begin
    if (game_reset) begin
      st_q   <= ST_AI;
      idle_q <= '0;
    end else begin
      case (st_q)
        ST_AI:    if (act_i)    st_q <= ST_HUMAN;
        ST_HUMAN: if (expire_o) st_q <= ST_AI;
        default:                st_q <= ST_AI;
      endcase

      if (act_i)
        idle_q <= '0;
      else if (fe_i && !at_max)
        idle_q <= idle_q + 1'b1;
    end
  end

endmodule

// File: rtl/bat_input_sched.sv
// Per-frame bat move scheduler: latches keys, accumulates mouse deltas, issues one move per bat
// the cycle after each vsync rising edge (frame_stb marks it); no backpressure, inputs are strobes.
module bat_input_sched
  import bat_input_sched_pkg::*;
#(
  parameter int MOVE_W        = MOVE_W_DEF,
  parameter int KEY_STEP      = KEY_STEP_DEF,
  parameter int WARMUP_FRAMES = WARMUP_FRAMES_DEF,
  parameter int IDLE_FRAMES   = IDLE_FRAMES_DEF
) (
  input  logic              fclk,
  input  logic              game_reset,
  input  logic              vsync,
  input  logic              key_stb,
  input  logic [1:0]        key_q_a,
  input  logic              msy_stb,
  input  logic [7:0]        mouse_y,
  output logic              l_human,
  output logic [MOVE_W-1:0] l_move,
  output logic              r_human,
  output logic [MOVE_W-1:0] r_move,
  output logic              frame_stb
);

  localparam int WW = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
  localparam logic signed [MOVE_W:0] ACC_MAX = (MOVE_W+1)'((2 ** (MOVE_W - 1)) - 1);
  localparam logic signed [MOVE_W:0] ACC_MIN = -ACC_MAX;
  localparam logic [MOVE_W-1:0] KMV_UP = MOVE_W'(-KEY_STEP);
  localparam logic [MOVE_W-1:0] KMV_DN = MOVE_W'(KEY_STEP);

  logic                     prev_vsync_q;
  logic [1:0]               key_q;
  logic [7:0]               prev_y_q;
  logic [WW-1:0]            warm_q, warm_d;
  logic signed [MOVE_W-1:0] r_acc_q, r_acc_d;
  logic [MOVE_W-1:0]        l_move_q, l_move_d;
  logic [MOVE_W-1:0]        r_move_q, r_move_d;
  logic                     frame_stb_q;

  logic                     fe;
  logic [7:0]               delta;
  logic signed [MOVE_W-1:0] d_ext;
  logic                     m_acc;
  logic                     l_act, r_act;
  logic                     l_hum, r_hum;
  logic                     l_exp, r_exp;
  logic signed [MOVE_W:0]   r_sum;
  logic signed [MOVE_W-1:0] r_sat;
  logic [MOVE_W-1:0]        l_key_mv;

  assign fe    = vsync & ~prev_vsync_q;
  assign delta = mouse_y - prev_y_q;
  assign d_ext = MOVE_W'($signed(delta));
  assign m_acc = msy_stb & (warm_q == '0);
  assign r_act = m_acc & (delta != 8'd0);
  assign l_act = key_stb & (key_q_a != 2'b00);

  bat_input_sched_src_fsm #(.IDLE_FRAMES(IDLE_FRAMES)) u_lfsm (
    .fclk       (fclk),
    .game_reset (game_reset),
    .fe_i       (fe),
    .act_i      (l_act),
    .human_o    (l_hum),
    .expire_o   (l_exp)
  );

  bat_input_sched_src_fsm #(.IDLE_FRAMES(IDLE_FRAMES)) u_rfsm (
    .fclk       (fclk),
    .game_reset (game_reset),
    .fe_i       (fe),
    .act_i      (r_act),
    .human_o    (r_hum),
    .expire_o   (r_exp)
  );

  // one guard bit so the sum can be clamped symmetrically to +/-(2^(MOVE_W-1)-1)
  always_comb begin
    r_sum = {r_acc_q[MOVE_W-1], r_acc_q} + {d_ext[MOVE_W-1], d_ext};
    if (r_sum > ACC_MAX)
      r_sat = ACC_MAX[MOVE_W-1:0];
    else if (r_sum < ACC_MIN)
      r_sat = ACC_MIN[MOVE_W-1:0];
    else
      r_sat = r_sum[MOVE_W-1:0];
  end

  always_comb begin
    l_key_mv = '0;
    case (key_dir(key_q))
      KD_UP:   l_key_mv = KMV_UP;
      KD_DOWN: l_key_mv = KMV_DN;
      default: l_key_mv = '0;
    endcase
  end

  // a delta arriving on the frame edge seeds the next frame rather than the one being issued
  always_comb begin
    r_acc_d  = r_acc_q;
    l_move_d = l_move_q;
    r_move_d = r_move_q;
    warm_d   = warm_q;
    if (fe) begin
      r_acc_d  = m_acc ? d_ext : '0;
      l_move_d = (l_hum && !l_exp) ? l_key_mv : '0;
      r_move_d = (r_hum && !r_exp) ? r_acc_q  : '0;
      if (warm_q != '0)
        warm_d = warm_q - 1'b1;
    end else if (m_acc) begin
      r_acc_d = r_sat;
    end
  end

  always_ff @(posedge fclk or posedge game_reset) begin
    if (game_reset) begin
      prev_vsync_q <= 1'b1;
      key_q        <= 2'b00;
      prev_y_q     <= '0;
      warm_q       <= WW'(WARMUP_FRAMES);
      r_acc_q      <= '0;
      l_move_q     <= '0;
      r_move_q     <= '0;
      frame_stb_q  <= 1'b0;
    end else begin
      prev_vsync_q <= vsync;
      if (key_stb) key_q    <= key_q_a;
      if (msy_stb) prev_y_q <= mouse_y;
      warm_q       <= warm_d;
      r_acc_q      <= r_acc_d;
      l_move_q     <= l_move_d;
      r_move_q     <= r_move_d;
      frame_stb_q  <= fe;
    end
  end

  assign l_human   = l_hum;
  assign r_human   = r_hum;
  assign l_move    = l_move_q;
  assign r_move    = r_move_q;
  assign frame_stb = frame_stb_q;

endmodule
